// File: rtl/uart_debug_pkg.sv
// Shared definitions for the UART debug master.
// Holds the command/response byte values of the serial protocol and the
// state encodings of the frame parser and the serial receiver.
package uart_debug_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ     = 8'h52;  // 'R'
    localparam logic [7:0] RSP_WRITE_OK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_READ_OK  = 8'h44;  // 'D'
    localparam logic [7:0] RSP_TIMEOUT  = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_debug_rx.sv
// 8N1 serial receiver for the debug master.
// Synchronizes rx, confirms a start bit at its half-period point, samples
// eight data bits (LSB first) and the stop bit at bit centres.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   rx          - raw serial input, idle high
//   data        - last received byte (valid together with valid)
//   valid       - one-cycle strobe, byte received with a good stop bit
//   frame_err   - one-cycle strobe, stop bit sampled low (byte dropped)
module uart_debug_rx
    import uart_debug_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int          HALF    = (int'(DIVISOR) + 1) / 2;
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    logic      rx_meta, rx_sync;
    rx_state_t state, state_next;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        tick;

    assign tick = (cnt == DIVISOR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (!rx_sync) state_next = RX_START;
            // A start shorter than half a bit is treated as noise.
            RX_START: if (cnt == HALF_M1) state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (tick) state_next = rx_sync ? RX_IDLE : RX_BREAK;
            // After a framing error, wait for the line to go high again so
            // the rest of a low stop bit is not taken as a new start.
            RX_BREAK: if (rx_sync) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            data      <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state != state_next || state == RX_IDLE || (state == RX_DATA && tick))
                cnt <= 16'd0;
            else
                cnt <= cnt + 16'd1;

            if (state == RX_START)
                bit_idx <= 3'd0;
            else if (state == RX_DATA && tick) begin
                bit_idx <= bit_idx + 3'd1;
                data    <= {rx_sync, data[7:1]};
            end

            valid     <= (state == RX_STOP) && tick && rx_sync;
            frame_err <= (state == RX_STOP) && tick && !rx_sync;
        end
    end

endmodule

// File: rtl/uart_debug_master.sv
// Serial-to-APB debug bridge.
// Receives 'W' addr[4] data[4] or 'R' addr[4] command frames over an 8N1
// line, runs one APB transfer, and answers with 'K', 'D' data[4] or 'E'
// (completer did not respond within TIMEOUT access cycles).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   rx, tx              - serial in / serial out, both idle high
//   apb_addr/sel/enable/write/wdata - APB requester outputs
//   apb_rdata, apb_ready            - APB completer inputs
//   busy                - a command frame or its response is in progress
// APB handshake: the transfer completes in the first ACCESS cycle in which
// apb_enable & apb_ready are both high; apb_rdata is captured in that cycle
// and address/control/write data are held constant from SETUP until then.
module uart_debug_master
    import uart_debug_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'd9,
    parameter int          TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] apb_addr,
    output logic        apb_sel,
    output logic        apb_enable,
    output logic        apb_write,
    output logic [31:0] apb_wdata,
    input  logic [31:0] apb_rdata,
    input  logic        apb_ready,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;
    parser_state_t state, state_next;
    logic [1:0]    byte_cnt;
    logic [31:0]   rdata_q;
    logic [7:0]    resp_code;
    logic [TW-1:0] to_cnt;
    logic [15:0]   tx_cnt;
    logic [3:0]    tx_bit;
    logic [2:0]    tx_byte;
    logic [2:0]    resp_last;
    logic [7:0]    cur_byte;
    logic [9:0]    tx_frame;
    logic          cmd_hit, tx_tick, last_bit, resp_done, to_expired;

    uart_debug_rx #(.DIVISOR(DIVISOR)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    assign cmd_hit    = rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ);
    assign tx_tick    = (tx_cnt == DIVISOR);
    assign last_bit   = tx_tick && (tx_bit == 4'd9);
    assign resp_last  = (resp_code == RSP_READ_OK) ? 3'd4 : 3'd0;
    assign resp_done  = last_bit && (tx_byte == resp_last);
    assign to_expired = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_hit) state_next = ST_ADDR;
            ST_ADDR: begin
                if (rx_ferr) state_next = ST_IDLE;
                else if (rx_valid && byte_cnt == 2'd3)
                    state_next = apb_write ? ST_DATA : ST_SETUP;
            end
            ST_DATA: begin
                if (rx_ferr) state_next = ST_IDLE;
                else if (rx_valid && byte_cnt == 2'd3) state_next = ST_SETUP;
            end
            ST_SETUP:  state_next = ST_ACCESS;
            // Ready on the final allowed cycle still counts as success.
            ST_ACCESS: if (apb_ready || to_expired) state_next = ST_RESP;
            ST_RESP:   if (resp_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        case (tx_byte)
            3'd0:    cur_byte = resp_code;
            3'd1:    cur_byte = rdata_q[7:0];
            3'd2:    cur_byte = rdata_q[15:8];
            3'd3:    cur_byte = rdata_q[23:16];
            default: cur_byte = rdata_q[31:24];
        endcase
    end

    // Start bit at index 0, data LSB first, stop bit at index 9.
    assign tx_frame   = {1'b1, cur_byte, 1'b0};
    assign tx         = (state == ST_RESP) ? tx_frame[tx_bit] : 1'b1;
    assign apb_sel    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign apb_enable = (state == ST_ACCESS);
    assign busy       = (state != ST_IDLE) || cmd_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            apb_addr  <= 32'd0;
            apb_wdata <= 32'd0;
            apb_write <= 1'b0;
            byte_cnt  <= 2'd0;
            rdata_q   <= 32'd0;
            resp_code <= 8'd0;
            to_cnt    <= '0;
            tx_cnt    <= 16'd0;
            tx_bit    <= 4'd0;
            tx_byte   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_hit) begin
                        apb_write <= (rx_data == CMD_WRITE);
                        byte_cnt  <= 2'd0;
                    end
                end
                // Little-endian: each new byte shifts in from the top.
                ST_ADDR: begin
                    if (rx_valid) begin
                        apb_addr <= {rx_data, apb_addr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        apb_wdata <= {rx_data, apb_wdata[31:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
                    end
                end
                ST_SETUP: to_cnt <= '0;
                ST_ACCESS: begin
                    to_cnt  <= to_cnt + 1'b1;
                    tx_cnt  <= 16'd0;
                    tx_bit  <= 4'd0;
                    tx_byte <= 3'd0;
                    if (apb_ready) begin
                        rdata_q   <= apb_rdata;
                        resp_code <= apb_write ? RSP_WRITE_OK : RSP_READ_OK;
                    end else if (to_expired) begin
                        resp_code <= RSP_TIMEOUT;
                    end
                end
                ST_RESP: begin
                    tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
                    if (tx_tick) tx_bit <= (tx_bit == 4'd9) ? 4'd0 : tx_bit + 4'd1;
                    if (last_bit) tx_byte <= tx_byte + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_master.sv
// Bench for uart_debug_master: table of directed transfers, hand-written
// line-noise / reset sequences and randomized transfers against a
// protocol-level response model.
module tb_uart_debug_master;
    localparam int TIMEOUT = 256;
    localparam int BIT_CYC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        tx;
    logic [31:0] apb_addr;
    logic        apb_sel, apb_enable, apb_write;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata = 32'd0;
    logic        apb_ready = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // completer behaviour and observations
    int          wait_n = 0;
    bit          hang = 1'b0;
    int          en_run = 0;
    int          en_len = 0;
    int          setup_cnt = 0;
    int          t_en_last = 0;
    int          t_tx_start = -1;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_write;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_en;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_cycles;
        bit          no_ready;
        int          nbytes;
        logic [39:0] exp_bytes;
        int          exp_en_len;
    } vec_t;

    vec_t vecs[4];

    uart_debug_master #(.DIVISOR(16'd9), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .tx         (tx),
        .apb_addr   (apb_addr),
        .apb_sel    (apb_sel),
        .apb_enable (apb_enable),
        .apb_write  (apb_write),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata),
        .apb_ready  (apb_ready),
        .busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB completer and access observer
    always @(negedge clk) begin
        if (reset) begin
            apb_ready = 1'b0;
            en_run = 0;
        end else if (apb_sel && apb_enable) begin
            apb_ready = !hang && (en_run == wait_n);
            en_run++;
            en_len++;
            t_en_last = cyc;
            acc_addr  = apb_addr;
            acc_write = apb_write;
            acc_wdata = apb_wdata;
        end else begin
            apb_ready = 1'b0;
            en_run = 0;
            if (apb_sel) setup_cnt++;
        end
        if (tx === 1'b0 && t_tx_start < 0) t_tx_start = cyc;
    end

    // tx line decoder
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT_CYC) @(negedge clk);
                check("tx_stop_bit", {31'd0, tx}, 32'd1);
                got_q.push_back(b);
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_cmd(input bit is_write, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] fr[$];
        fr.push_back(is_write ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) fr.push_back(addr[8*i +: 8]);
        if (is_write) for (int i = 0; i < 4; i++) fr.push_back(wdata[8*i +: 8]);
        foreach (fr[i]) begin
            send_byte(fr[i], 1'b1);
            if (i == 0) check("busy_after_cmd", {31'd0, busy}, 32'd1);
        end
    endtask

    // reference model: response bytes from the protocol rules
    task automatic model_expect(input bit is_write, input bit no_ready, input int wcyc,
                                input logic [31:0] rdata);
        exp_q.delete();
        if (no_ready) begin
            exp_q.push_back(8'h45);
            exp_en = TIMEOUT;
        end else begin
            exp_en = wcyc + 1;
            if (is_write) exp_q.push_back(8'h4B);
            else begin
                exp_q.push_back(8'h44);
                for (int i = 0; i < 4; i++) exp_q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
            end
        end
    endtask

    // runs one transfer and compares against exp_q / exp_en
    task automatic do_txn(input bit is_write, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wcyc, input bit no_ready, input logic [31:0] rdata);
        bit done;
        int t_end;
        wait_n = wcyc;
        hang = no_ready;
        apb_rdata = rdata;
        en_len = 0;
        setup_cnt = 0;
        t_tx_start = -1;
        got_q.delete();
        send_cmd(is_write, addr, wdata);
        done = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        t_end = cyc;
        check("busy_falls", {31'd0, done}, 32'd1);
        repeat (20) @(negedge clk);
        check("resp_len", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) check("resp_byte", got_q[i], exp_q[i]);
        check("enable_cycles", en_len, exp_en);
        check("setup_cycles", setup_cnt, 1);
        check("apb_addr", acc_addr, addr);
        check("apb_write", {31'd0, acc_write}, {31'd0, is_write});
        if (is_write) check("apb_wdata", acc_wdata, wdata);
        check("tx_start_gap", t_tx_start - t_en_last, 1);
        check("resp_duration", t_end - t_tx_start, exp_q.size() * BIT_CYC * BIT_CYC);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] junk;
        bit got_en;

        vecs[0] = '{1'b1, 32'hC000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1, 40'h00_0000_004B, 1};
        vecs[1] = '{1'b0, 32'hC000_0004, 32'h0, 32'h1234_5678, 5, 1'b0, 5, 40'h12_3456_7844, 6};
        vecs[2] = '{1'b0, 32'h0000_1000, 32'h0, 32'hAAAA_5555, 0, 1'b1, 1, 40'h00_0000_0045, TIMEOUT};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 2, 1'b0, 1, 40'h00_0000_004B, 3};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_sel", {31'd0, apb_sel}, 32'd0);
        check("rst_enable", {31'd0, apb_enable}, 32'd0);
        check("rst_write", {31'd0, apb_write}, 32'd0);
        check("rst_addr", apb_addr, 32'd0);
        check("rst_wdata", apb_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // directed table
        for (int v = 0; v < 4; v++) begin
            exp_q.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) exp_q.push_back(vecs[v].exp_bytes[8*i +: 8]);
            exp_en = vecs[v].exp_en_len;
            do_txn(vecs[v].is_write, vecs[v].addr, vecs[v].wdata, vecs[v].wait_cycles,
                   vecs[v].no_ready, vecs[v].rdata);
        end

        // short low glitch, immediately followed by a real read
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        model_expect(1'b0, 1'b0, 1, 32'hCAFE_F00D);
        do_txn(1'b0, 32'h4000_0008, 32'h0, 1, 1'b0, 32'hCAFE_F00D);

        // 'W' with a low stop bit must not start a frame
        send_byte(8'h57, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_busy", {31'd0, busy}, 32'd0);
        model_expect(1'b0, 1'b0, 0, 32'h0BAD_CAFE);
        do_txn(1'b0, 32'h1234_0000, 32'h0, 0, 1'b0, 32'h0BAD_CAFE);

        // stray non-command byte
        send_byte(8'h00, 1'b1);
        repeat (5) @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        model_expect(1'b1, 1'b0, 0, 32'h0);
        do_txn(1'b1, 32'h0000_00FC, 32'h0102_0304, 0, 1'b0, 32'h0);

        // reset during ACCESS
        hang = 1'b1;
        got_q.delete();
        send_cmd(1'b0, 32'h5000_0000, 32'h0);
        got_en = 1'b0;
        for (int k = 0; k < 200 && !got_en; k++) begin
            @(negedge clk);
            if (apb_enable) got_en = 1'b1;
        end
        check("rst_mid_reached_access", {31'd0, got_en}, 32'd1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_sel", {31'd0, apb_sel}, 32'd0);
        check("rst_mid_enable", {31'd0, apb_enable}, 32'd0);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_no_resp", got_q.size(), 0);
        model_expect(1'b0, 1'b0, 3, 32'h8765_4321);
        do_txn(1'b0, 32'h5000_0004, 32'h0, 3, 1'b0, 32'h8765_4321);

        // randomized transfers against the model
        for (int n = 0; n < 12; n++) begin
            bit          w, h;
            int          wc;
            logic [31:0] a, d, r;
            w  = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 7) == 0);
            wc = $urandom_range(0, 6);
            a  = $urandom;
            d  = $urandom;
            r  = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
                send_byte(junk, 1'b1);
                repeat (3) @(negedge clk);
                check("junk_busy", {31'd0, busy}, 32'd0);
            end
            model_expect(w, h, wc, r);
            do_txn(w, a, d, wc, h, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_debug_master.md
# uart_debug_master

Host-side debug bridge: receives command frames over a serial line, executes them as APB transfers on the SoC peripheral bus, and returns a response frame. It is the APB requester counterpart to the APB-completer UART peripheral, using the same 8N1 line format and bit-period convention. It lets a PC read and write any APB register, including the UART's, without CPU involvement.

## Interface
- DIVISOR, 16'd9: bit period is DIVISOR+1 clk cycles; fixed at elaboration.
- TIMEOUT, 256: maximum access-phase cycles waiting for apb_ready before abort.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rx  input  1  serial in, idle high, asynchronous to clk.
- tx  output  1  serial out, idle high.
- apb_addr  output  32  transfer address.
- apb_sel  output  1  APB select.
- apb_enable  output  1  APB access phase.
- apb_write  output  1  1 = write, 0 = read.
- apb_wdata  output  32  write data.
- apb_rdata  input  32  read data, valid when apb_enable & apb_ready.
- apb_ready  input  1  completer ready.
- busy  output  1  high from first byte of a frame until the last response stop bit ends.

## Operation
- Line format: 8N1, LSB first; every bit lasts DIVISOR+1 cycles.
- rx passes a 2-FF synchronizer before use.
- Receiver: a low level in idle starts a half-period wait ((DIVISOR+1)/2 cycles, floor). If rx is still low, the start is confirmed; otherwise the receiver returns to idle.
  - Samples 8 data bits and the stop bit at bit centres.
  - A low stop bit is a framing error: the byte is discarded and the frame parser returns to IDLE.
- Frame parser states:
  - IDLE: 0x57 'W' → ADDR with write=1; 0x52 'R' → ADDR with write=0; any other byte is ignored.
  - ADDR: 4 bytes little-endian into apb_addr. Goes to DATA if write, else SETUP.
  - DATA: 4 bytes little-endian into apb_wdata, then SETUP.
  - SETUP: apb_sel=1, apb_enable=0 for exactly one cycle, then ACCESS.
  - ACCESS: apb_sel=1 and apb_enable=1 until apb_ready.
    - On apb_ready: read data is captured from apb_rdata, then RESP.
    - After TIMEOUT cycles without apb_ready: sel and enable drop and the response is the error reply, then RESP.
  - RESP: transmits the response, then returns to IDLE.
- Responses:
  - Write OK: 0x4B 'K'.
  - Read OK: 0x44 'D' followed by 4 data bytes little-endian.
  - Timeout: 0x45 'E' only.
- Bytes received in SETUP, ACCESS or RESP are dropped. The receiver keeps tracking the line so it stays aligned.
- Transmitter: start bit low, 8 data bits, stop bit high. Back-to-back response bytes start immediately after the previous stop bit. Between frames tx=1.
- Reset asserted mid-operation: everything aborts immediately. apb_sel and apb_enable go low, tx goes high, the parser enters IDLE, and no response is sent.

## Timing
- Reset values: tx=1, apb_sel=0, apb_enable=0, apb_write=0, apb_addr=0, apb_wdata=0, busy=0.
- Receive latency: a byte is accepted 2 cycles (synchronizer) after the stop-bit sample point.
- The SETUP cycle begins in the cycle after the last command byte is accepted.
- ACCESS ends in the cycle where apb_enable & apb_ready. In the following cycle apb_sel=0, apb_enable=0, and the start bit of the first response byte begins.
- apb_addr, apb_write and apb_wdata are stable from SETUP through the end of ACCESS.
- Timeout counter: starts at 0 on entry to ACCESS. Abort happens when the count reaches TIMEOUT with apb_ready low. If apb_ready arrives on that same cycle, the transfer succeeds.
- busy rises in the cycle a valid command byte is accepted. It falls in the cycle after the last stop bit period completes.

## Structure
- Package uart_debug_pkg:
  - Command and response byte constants ('W', 'R', 'K', 'D', 'E').
  - Parser state enum (IDLE, ADDR, DATA, SETUP, ACCESS, RESP).
- Sub-module uart_debug_rx: synchronizer, start detection, bit sampling and framing check. It outputs a byte and a one-cycle valid strobe.
- The transmitter, parser and APB sequencing stay in the top module.

## Test plan
- Write transfer: rx bytes 57 10 00 00 C0 EF BE AD DE with completer ready at once → one SETUP cycle, then an access with apb_addr=C0000010, apb_write=1, apb_wdata=DEADBEEF; tx returns 4B.
- Read with wait states: 52 04 00 00 C0, completer holds apb_ready low for 5 access cycles and returns 12345678 → apb_enable high for exactly 6 cycles; tx returns 44 78 56 34 12.
- Timeout: read with apb_ready held low → apb_enable drops after TIMEOUT cycles; tx returns 45 only.
- Line noise:
  - A 3-cycle low glitch on rx produces no byte.
  - A byte 0x57 with a low stop bit is discarded and the parser stays in IDLE.
  - A stray byte 0x00 in IDLE is ignored.
- Reset during ACCESS: apb_sel and apb_enable are 0 and tx is 1 immediately. No response is sent, and a following valid read completes normally.
- Bit timing: with DIVISOR=9, every tx bit lasts exactly 10 cycles and the whole response to a read is 50 bits = 500 cycles.
